// File: rtl/util_cp_remove_pkg.sv
// Shared types and NR numerology constants for the cyclic-prefix removal stage.
package util_cp_remove_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int NR_CP_SHORT_4096  = 288;
    localparam int NR_CP_LONG_4096   = 352;
    localparam int NR_CP_SHORT_2048  = 144;
    localparam int NR_CP_LONG_2048   = 176;
    localparam int NR_SYM_PER_SLOT   = 14;
    localparam int NR_LONG_CP_PERIOD = 14;

    // Long/short CP length for the supported FFT sizes (4096 for anything else).
    function automatic int nr_cp_len(input int fft_size, input bit long_cp);
        if (fft_size == 2048) return long_cp ? NR_CP_LONG_2048 : NR_CP_SHORT_2048;
        return long_cp ? NR_CP_LONG_4096 : NR_CP_SHORT_4096;
    endfunction

endpackage

// File: rtl/util_skid_reg.sv
// One-entry valid/ready output register carrying an IQ sample and its frame flags.
module util_skid_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int SYM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_real_i,
    input  logic [DATA_WIDTH-1:0] in_imag_i,
    input  logic                  in_sop_i,
    input  logic                  in_eop_i,
    input  logic [SYM_WIDTH-1:0]  in_sym_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_real_o,
    output logic [DATA_WIDTH-1:0] out_imag_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic [SYM_WIDTH-1:0]  out_sym_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] real_q, imag_q;
    logic                  sop_q, eop_q;
    logic [SYM_WIDTH-1:0]  sym_q;

    assign in_ready_o = ~valid_q | out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            real_q  <= '0;
            imag_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sym_q   <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            real_q  <= in_real_i;
            imag_q  <= in_imag_i;
            sop_q   <= in_sop_i;
            eop_q   <= in_eop_i;
            sym_q   <= in_sym_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_real_o  = real_q;
    assign out_imag_o  = imag_q;
    assign out_sop_o   = sop_q;
    assign out_eop_o   = eop_q;
    assign out_sym_o   = sym_q;

endmodule

// File: rtl/util_cp_remove.sv
// Drops the cyclic prefix of each OFDM symbol and forwards FFT_SIZE samples per symbol
// with sop/eop and symbol index; resynchronises on an unexpected slot marker.
module util_cp_remove
    import util_cp_remove_pkg::*;
#(
    parameter int FFT_SIZE       = 4096,
    parameter int INDX_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int CP_LEN_SHORT   = nr_cp_len(4096, 1'b0),
    parameter int CP_LEN_LONG    = nr_cp_len(4096, 1'b1),
    parameter int SYM_PER_SLOT   = NR_SYM_PER_SLOT,
    parameter int LONG_CP_PERIOD = NR_LONG_CP_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_sop,
    input  logic [DATA_WIDTH-1:0] din_real,
    input  logic [DATA_WIDTH-1:0] din_imag,
    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic                  dout_sop,
    output logic                  dout_eop,
    output logic [DATA_WIDTH-1:0] dout_real,
    output logic [DATA_WIDTH-1:0] dout_imag,
    output logic [3:0]            dout_sym_idx,
    output logic                  resync_err
);

    localparam logic [INDX_WIDTH-1:0] LAST_IDX     = INDX_WIDTH'(FFT_SIZE - 1);
    localparam logic [INDX_WIDTH-1:0] CP_LAST_LONG = INDX_WIDTH'(CP_LEN_LONG - 1);
    localparam logic [INDX_WIDTH-1:0] CP_LAST_SHRT = INDX_WIDTH'(CP_LEN_SHORT - 1);
    localparam logic [3:0]            LAST_SYM     = 4'(SYM_PER_SLOT - 1);

    state_t                state_q, state_d;
    logic [INDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]            sym_q, sym_d;
    logic                  resync_q, resync_d;

    logic                  skid_rdy, in_beat, fwd, sop_expected, is_long;
    logic [31:0]           sym_ext;
    logic [INDX_WIDTH-1:0] cp_last;

    assign sym_ext      = 32'(sym_q);
    assign is_long      = (sym_ext % 32'(LONG_CP_PERIOD)) == 32'd0;
    assign cp_last      = is_long ? CP_LAST_LONG : CP_LAST_SHRT;
    assign din_ready    = (state_q == ST_DATA) ? skid_rdy : 1'b1;
    assign in_beat      = din_valid & din_ready;
    // Only the very first CP beat of symbol 0 following a completed slot can carry a legal marker.
    assign sop_expected = (state_q == ST_CP) && (cnt_q == '0) && (sym_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        resync_d = 1'b0;
        fwd      = 1'b0;
        if (in_beat) begin
            if (din_sop && (state_q == ST_IDLE || !sop_expected)) begin
                // The marker beat is CP sample 0 of symbol 0.
                resync_d = (state_q != ST_IDLE);
                sym_d    = '0;
                if (CP_LAST_LONG == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_CP;
                    cnt_d   = INDX_WIDTH'(1);
                end
            end else begin
                case (state_q)
                    ST_CP: begin
                        if (cnt_q == cp_last) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + INDX_WIDTH'(1);
                        end
                    end
                    ST_DATA: begin
                        fwd = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_CP;
                            cnt_d   = '0;
                            sym_d   = (sym_q == LAST_SYM) ? 4'd0 : sym_q + 4'd1;
                        end else begin
                            cnt_d = cnt_q + INDX_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sym_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            resync_q <= resync_d;
        end
    end

    assign resync_err = resync_q;

    util_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYM_WIDTH  (4)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (fwd),
        .in_ready_o  (skid_rdy),
        .in_real_i   (din_real),
        .in_imag_i   (din_imag),
        .in_sop_i    (cnt_q == '0),
        .in_eop_i    (cnt_q == LAST_IDX),
        .in_sym_i    (sym_q),
        .out_valid_o (dout_valid),
        .out_ready_i (dout_ready),
        .out_real_o  (dout_real),
        .out_imag_o  (dout_imag),
        .out_sop_o   (dout_sop),
        .out_eop_o   (dout_eop),
        .out_sym_o   (dout_sym_idx)
    );

endmodule

// File: tb/tb_util_cp_remove.sv
// Directed bench for util_cp_remove with a reduced numerology and a scoreboard model.
module tb_util_cp_remove;

    localparam int N    = 64;
    localparam int IW   = 6;
    localparam int DW   = 16;
    localparam int CPS  = 5;
    localparam int CPL  = 9;
    localparam int SPS  = 14;
    localparam int LCP  = 14;
    localparam int SLOT = CPL + (SPS - 1) * CPS + SPS * N;

    localparam int M_IDLE = 0;
    localparam int M_CP   = 1;
    localparam int M_DATA = 2;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
        logic [3:0]    sym;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0, din_sop = 1'b0, dout_ready = 1'b0;
    logic [DW-1:0] din_real = '0, din_imag = '0;
    logic          din_ready, dout_valid, dout_sop, dout_eop, resync_err;
    logic [DW-1:0] dout_real, dout_imag;
    logic [3:0]    dout_sym_idx;

    util_cp_remove #(
        .FFT_SIZE(N), .INDX_WIDTH(IW), .DATA_WIDTH(DW), .CP_LEN_SHORT(CPS),
        .CP_LEN_LONG(CPL), .SYM_PER_SLOT(SPS), .LONG_CP_PERIOD(LCP)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din_sop(din_sop),
        .din_real(din_real), .din_imag(din_imag), .dout_ready(dout_ready),
        .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_real(dout_real), .dout_imag(dout_imag), .dout_sym_idx(dout_sym_idx),
        .resync_err(resync_err)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    exp_t q[$];
    int   m_mode = M_IDLE, m_pos = 0, m_sym = 0;
    logic exp_rs = 1'b0;
    logic [DW-1:0] in_cnt = '0;
    logic prev_stall = 1'b0;
    exp_t prev_out;
    int   rs_seen = 0, out_beats = 0, sops = 0, eops = 0;
    logic ph1 = 1'b0, post_rs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t cur_out();
        exp_t o;
        o.re = dout_real; o.im = dout_imag; o.sop = dout_sop; o.eop = dout_eop; o.sym = dout_sym_idx;
        return o;
    endfunction

    task automatic model(input logic sop, input logic [DW-1:0] re, input logic [DW-1:0] im);
        exp_t e;
        int cpl;
        if (m_mode == M_IDLE) begin
            if (sop) begin m_sym = 0; m_mode = M_CP; m_pos = 1; end
        end else if (sop && !(m_mode == M_CP && m_pos == 0 && m_sym == 0)) begin
            exp_rs = 1'b1; m_sym = 0; m_mode = M_CP; m_pos = 1;
        end else if (m_mode == M_CP) begin
            cpl = (m_sym % LCP == 0) ? CPL : CPS;
            if (m_pos == cpl - 1) begin m_mode = M_DATA; m_pos = 0; end
            else m_pos++;
        end else begin
            e.re = re; e.im = im; e.sop = (m_pos == 0); e.eop = (m_pos == N - 1); e.sym = 4'(m_sym);
            q.push_back(e);
            if (m_pos == N - 1) begin
                m_pos = 0; m_mode = M_CP; m_sym = (m_sym == SPS - 1) ? 0 : m_sym + 1;
            end else m_pos++;
        end
    endtask

    // One clock cycle: drive, check comb outputs, score beats, advance, check resync pulse.
    task automatic step(input logic v, input logic s, input logic rdy);
        exp_t e;
        logic exp_rdy;
        if (prev_stall) chk("stable_while_stalled", 64'(cur_out()), 64'(prev_out));
        exp_rs = 1'b0;
        din_valid = v; din_sop = s; dout_ready = rdy;
        if (v && s) in_cnt = '0;
        din_real = in_cnt; din_imag = in_cnt ^ 16'hA5A5;
        #1;
        chk("dout_valid", 64'(dout_valid), 64'(q.size() != 0));
        exp_rdy = (m_mode != M_DATA) || (q.size() == 0) || rdy;
        chk("din_ready", 64'(din_ready), 64'(exp_rdy));
        if (dout_valid && dout_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("dout_beat", 64'(cur_out()), 64'(e));
            out_beats++;
            if (dout_sop) begin
                if (ph1) chk("ph1_sop_position", 64'(dout_real),
                             64'((sops / SPS) * SLOT + CPL + (sops % SPS) * (N + CPS)));
                if (post_rs) begin
                    chk("post_resync_first", 64'({dout_sym_idx, dout_real}), 64'({4'd0, 16'(CPL)}));
                    post_rs = 1'b0;
                end
                sops++;
            end
            if (dout_eop) eops++;
        end
        prev_stall = dout_valid & ~dout_ready;
        prev_out   = cur_out();
        if (din_valid && din_ready) begin
            model(s, din_real, din_imag);
            in_cnt++;
        end
        @(posedge clk); #1;
        chk("resync_err", 64'(resync_err), 64'(exp_rs));
        if (resync_err) rs_seen++;
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1; din_valid = 1'b0; din_sop = 1'b0; dout_ready = 1'b0;
        repeat (cyc) @(posedge clk);
        #1; rst = 1'b0;
        q.delete(); m_mode = M_IDLE; m_pos = 0; m_sym = 0; exp_rs = 1'b0; prev_stall = 1'b0;
        chk("rst_dout", 64'({dout_valid, dout_sop, dout_eop, dout_real, dout_imag, dout_sym_idx, resync_err}), 64'(0));
        chk("rst_din_ready", 64'(din_ready), 64'(1));
    endtask

    initial begin
        int n;
        // Reset, then samples without a slot marker: nothing comes out.
        do_reset(3);
        out_beats = 0;
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 1'b1);
        chk("no_sop_no_output", 64'(out_beats), 64'(0));

        // Two back-to-back slots with a single marker, full-rate.
        ph1 = 1'b1; sops = 0; eops = 0; out_beats = 0; rs_seen = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 2 * SLOT; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        ph1 = 1'b0;
        chk("two_slot_sops", 64'(sops), 64'(2 * SPS));
        chk("two_slot_eops", 64'(eops), 64'(2 * SPS));
        chk("two_slot_beats", 64'(out_beats), 64'(2 * SPS * N));
        chk("two_slot_no_resync", 64'(rs_seen), 64'(0));

        // Random backpressure on a continuous input stream.
        for (int i = 0; i < 700; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("bp_no_resync", 64'(rs_seen), 64'(0));

        // Marker injected mid-symbol 3.
        n = 0;
        while (!(m_mode == M_DATA && m_sym == 3 && m_pos == 30) && n < 3000) begin
            step(1'b1, 1'b0, 1'b1); n++;
        end
        chk("reach_sym3_timeout", 64'(n < 3000), 64'(1));
        eops = 0;
        post_rs = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b1);
        chk("resync_pulses", 64'(rs_seen), 64'(1));
        chk("post_resync_seen", 64'(post_rs), 64'(0));

        // Reset while an output beat is stalled in DATA.
        n = 0;
        while (!(m_mode == M_DATA && q.size() > 0 && m_pos > 3) && n < 3000) begin
            step(1'b1, 1'b0, 1'b0); n++;
        end
        chk("reach_stall_timeout", 64'(n < 3000), 64'(1));
        chk("stall_pending", 64'(dout_valid), 64'(1));
        do_reset(1);
        out_beats = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("post_rst_discard", 64'(out_beats), 64'(0));

        // Restart cleanly and drain.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < CPL + N + 10; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
